// File: rtl/vec_seq_alu_pkg.sv
// rtl/vec_seq_alu_pkg.sv - op codes, element-size codes, FSM states and immediate broadcast helper
package vec_seq_alu_pkg;

  typedef enum logic [2:0] {
    VOP_ADD = 3'd0,
    VOP_SUB = 3'd1,
    VOP_AND = 3'd2,
    VOP_OR  = 3'd3,
    VOP_XOR = 3'd4,
    VOP_SLT = 3'd5
  } vop_e;

  localparam logic [1:0] ESIZE_B = 2'b00;
  localparam logic [1:0] ESIZE_H = 2'b01;
  localparam logic [1:0] ESIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One 32-bit word of the broadcast immediate; byte mode truncates after sign extension.
  function automatic logic [31:0] imm_word(input logic [1:0] esize, input logic [9:0] imm);
    logic [31:0] w;
    case (esize)
      ESIZE_B: w = {4{imm[7:0]}};
      ESIZE_H: w = {2{{6{imm[9]}}, imm}};
      default: w = {{22{imm[9]}}, imm};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/vec_seq_alu_slice_alu.sv
// rtl/vec_seq_alu_slice_alu.sv - combinational DP_BITS slice ALU with per-element carry isolation
module vec_slice_alu
  import vec_seq_alu_pkg::*;
#(
  parameter int DP_BITS = 32
) (
  input  logic [2:0]         op,
  input  logic [1:0]         esize,
  input  logic               sat,
  input  logic [DP_BITS-1:0] a,
  input  logic [DP_BITS-1:0] b,
  output logic [DP_BITS-1:0] res,
  output logic               ovf
);

  localparam int WORDS = DP_BITS / 32;

  // Returns {overflow, result}; operands are the low n bits of a/b, result is valid in its low n bits.
  function automatic logic [32:0] elem_op(input logic [2:0] eop, input logic esat,
                                          input logic [31:0] ea, input logic [31:0] eb,
                                          input int n);
    logic signed [31:0] ta, tb;
    logic signed [33:0] sa, sb, sum, smax, smin;
    logic [31:0] r;
    logic o;
    ta   = $signed(ea << (32 - n)) >>> (32 - n);
    tb   = $signed(eb << (32 - n)) >>> (32 - n);
    sa   = 34'(ta);
    sb   = 34'(tb);
    smax = (34'sd1 <<< (n - 1)) - 34'sd1;
    smin = -(34'sd1 <<< (n - 1));
    sum  = '0;
    r    = '0;
    o    = 1'b0;
    case (eop)
      VOP_ADD, VOP_SUB: begin
        sum = (eop == VOP_ADD) ? sa + sb : sa - sb;
        o   = (sum > smax) || (sum < smin);
        if (esat && o) sum = (sum > smax) ? smax : smin;
        r   = sum[31:0];
      end
      VOP_SLT: r = {31'd0, sa < sb};
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  logic [31:0] aw, bw, word;
  logic [32:0] t;

  always_comb begin
    res  = '0;
    ovf  = 1'b0;
    aw   = '0;
    bw   = '0;
    word = '0;
    t    = '0;
    for (int w = 0; w < WORDS; w++) begin
      aw   = a[32*w +: 32];
      bw   = b[32*w +: 32];
      word = '0;
      case (op)
        VOP_AND: word = aw & bw;
        VOP_OR:  word = aw | bw;
        VOP_XOR: word = aw ^ bw;
        default: begin
          case (esize)
            ESIZE_B: begin
              for (int e = 0; e < 4; e++) begin
                t = elem_op(op, sat, aw >> (8 * e), bw >> (8 * e), 8);
                word[8*e +: 8] = t[7:0];
                ovf = ovf | t[32];
              end
            end
            ESIZE_H: begin
              for (int e = 0; e < 2; e++) begin
                t = elem_op(op, sat, aw >> (16 * e), bw >> (16 * e), 16);
                word[16*e +: 16] = t[15:0];
                ovf = ovf | t[32];
              end
            end
            default: begin
              t = elem_op(op, sat, aw, bw, 32);
              word = t[31:0];
              ovf = ovf | t[32];
            end
          endcase
        end
      endcase
      res[32*w +: 32] = word;
    end
  end

endmodule

// File: rtl/vec_seq_alu.sv
// rtl/vec_seq_alu.sv - multi-beat SIMD vector ALU: FSM, beat counter, operand/result registers
module vec_seq_alu
  import vec_seq_alu_pkg::*;
#(
  parameter int VLEN_BITS = 128,
  parameter int DP_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [1:0]           esize,
  input  logic                 sat,
  input  logic                 use_imm,
  input  logic [9:0]           imm,
  input  logic [VLEN_BITS-1:0] src_a,
  input  logic [VLEN_BITS-1:0] src_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VLEN_BITS-1:0] result,
  output logic                 ovf,
  output logic                 busy
);

  localparam int BEATS = VLEN_BITS / DP_BITS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e               state;
  logic [BW-1:0]        beat;
  logic [VLEN_BITS-1:0] a_q, b_q, b_sel;
  logic [2:0]           op_q;
  logic [1:0]           esize_q;
  logic                 sat_q;
  logic [DP_BITS-1:0]   slice_res;
  logic                 slice_ovf;

  // Operand B is resolved at accept so the slice ALU never needs to know about the immediate.
  always_comb begin
    b_sel = use_imm ? {(VLEN_BITS/32){imm_word(esize, imm)}} : src_b;
  end

  vec_slice_alu #(.DP_BITS(DP_BITS)) u_slice (
    .op    (op_q),
    .esize (esize_q),
    .sat   (sat_q),
    .a     (a_q[beat*DP_BITS +: DP_BITS]),
    .b     (b_q[beat*DP_BITS +: DP_BITS]),
    .res   (slice_res),
    .ovf   (slice_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      beat      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      esize_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state    <= ST_BUSY;
            beat     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            result   <= '0;
            ovf      <= 1'b0;
            a_q      <= src_a;
            b_q      <= b_sel;
            op_q     <= op;
            esize_q  <= esize;
            sat_q    <= sat;
          end
        end
        ST_BUSY: begin
          result[beat*DP_BITS +: DP_BITS] <= slice_res;
          ovf <= ovf | slice_ovf;
          if (beat == BW'(BEATS - 1)) begin
            state     <= ST_DONE;
            beat      <= '0;
            out_valid <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
